// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor (a - b - bin), one bit per clock, LSB first, valid/ready on both sides.
// Optional signed-overflow output ovf is compiled in when SUB_OVF_EN is defined.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             br;
    logic [CW-1:0]    cnt;

    logic d_bit;
    logic br_next;

    // Full-subtractor cell applied to the current LSBs of the operand shift registers.
    assign d_bit   = a_sr[0] ^ b_sr[0] ^ br;
    assign br_next = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);

    // NOTE: all state lives in this one clocked block and is assigned with <= so every
    // register samples the pre-edge values of the others, regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            a_sr      <= '0;
            b_sr      <= '0;
            br        <= 1'b0;
            cnt       <= '0;
            diff      <= '0;
            bout      <= 1'b0;
`ifdef SUB_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sr     <= a;
                        b_sr     <= b;
                        br       <= bin;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    diff <= {d_bit, diff[WIDTH-1:1]};
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    br   <= br_next;
                    cnt  <= cnt + CW'(1);
                    if (cnt == LAST_BIT) begin
                        // bout gets its own register so the next accept's bin load leaves it intact.
                        bout      <= br_next;
`ifdef SUB_OVF_EN
                        ovf       <= br ^ br_next;
`endif
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial unsigned subtractor with borrow-in/borrow-out: the sequential, inverse-direction companion to the team's ripple-carry adder. It accepts two WIDTH-bit operands and a borrow-in through a valid/ready handshake. It resolves one bit per clock, LSB first, using a single borrow flip-flop, then holds the difference until the consumer accepts it. It trades latency for area in datapaths where a parallel subtractor is not justified.

## Interface
- WIDTH, 4, operand/result width in bits (≥2)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands valid
- in_ready  output  1  block can accept operands (IDLE only)
- a  input  WIDTH  minuend
- b  input  WIDTH  subtrahend
- bin  input  1  borrow-in
- out_valid  output  1  result valid (DONE only)
- out_ready  input  1  consumer accepts result
- diff  output  WIDTH  (a − b − bin) mod 2^WIDTH
- bout  output  1  borrow-out: 1 iff a < b + bin (unsigned)
- ovf  output  1  signed overflow; present only with SUB_OVF_EN

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE
  - in_ready=1, out_valid=0.
  - On in_valid & in_ready: latch a, b into shift registers; load borrow FF with bin; clear bit counter; go to SHIFT.
- SHIFT
  - in_ready=0, out_valid=0; in_valid, a, b and bin are ignored.
  - Each cycle, with i = counter and br = borrow FF:
    - d_i = a_i ^ b_i ^ br
    - br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br)
  - d_i shifts into the diff register from the MSB side; the operand registers shift right; the counter increments.
  - After bit WIDTH−1 is processed, go to DONE.
- DONE
  - out_valid=1; diff and bout are stable.
  - bout is the final borrow FF value.
  - On out_ready: go to IDLE.
  - diff and bout keep their values until the next transaction overwrites them.
- Arithmetic
  - All arithmetic is unsigned modulo 2^WIDTH.
  - Wrap-around is reported only through bout (and ovf when compiled in).
- The counter is clog2(WIDTH) bits wide and returns to 0 on each accept.

## Timing
- Reset (async assert, sync-released by the environment):
  - state=IDLE
  - in_ready=1
  - out_valid=0
  - diff=0
  - bout=0
  - ovf=0
  - counter, borrow FF and shift registers cleared.
- Latency:
  - The accept handshake occurs at edge E0.
  - Edges E1…E_WIDTH process bits 0…WIDTH−1.
  - out_valid is high immediately after edge E_WIDTH, i.e. WIDTH cycles after accept.
- Backpressure:
  - With out_ready low, the block stays in DONE indefinitely with outputs frozen.
- Return to IDLE:
  - An out_ready-accepted edge returns the FSM to IDLE.
  - in_ready rises after that edge. There is no same-cycle result-accept/operand-accept overlap.
  - Minimum throughput is one result per WIDTH+2 cycles.
- Reset mid-operation:
  - rst_n low in any state immediately forces the reset values.
  - Any partial result is discarded and is never presented.
- Simultaneous events:
  - in_valid while in SHIFT or DONE has no effect.
  - out_ready outside DONE has no effect.

## Configuration
- SUB_OVF_EN defined:
  - Port ovf exists.
  - ovf = (borrow into MSB) XOR (borrow out of MSB), captured when the MSB is processed.
  - ovf is valid with out_valid and is reset to 0.
- SUB_OVF_EN undefined:
  - Port ovf and its flip-flop are absent.
  - All other behaviour is identical.

## Test plan
- Reset:
  - Assert rst_n=0 mid-cycle. Required: in_ready=1, out_valid=0, diff=0000, bout=0 asynchronously.
  - Release and hold 2 cycles. Required: values unchanged.
- Basic subtraction:
  - a=0111, b=0010, bin=0, accepted at E0.
  - Required: out_valid=1 after E4 with diff=0101, bout=0; in_ready=0 during E1–E4.
- Underflow:
  - a=0000, b=0001, bin=0. Required: diff=1111, bout=1.
  - a=1001, b=1111, bin=1. Required: diff=1001, bout=1 (ovf=0 with SUB_OVF_EN).
- Signed overflow (SUB_OVF_EN):
  - a=1000, b=0001, bin=0. Required: diff=0111, bout=0, ovf=1.
- Backpressure:
  - Hold out_ready=0 for 3 cycles in DONE while driving in_valid=1 with new operands.
  - Required: diff/bout unchanged and in_ready=0 throughout.
  - Raise out_ready. Required: in_ready=1 next cycle, and the new operands are accepted then.
- Reset mid-SHIFT:
  - Pulse rst_n low after E2 of a transaction.
  - Required: out_valid never asserts for it.
  - A following transaction a=1100, b=0011, bin=1 must produce diff=1000, bout=0.
